// File: rtl/room_light_pkg.sv
// Shared types and helpers for the room lighting controller.
// Channel state encoding, count-width helper and a 16-bit popcount.
package room_light_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      OCC  = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int MAX_ROOMS = 16;

   function automatic int cw(input int n_rooms);
      return $clog2(n_rooms + 1);
   endfunction

   function automatic logic [4:0] popcount(input logic [MAX_ROOMS-1:0] v);
      logic [4:0] sum;
      sum = '0;
      for (int i = 0; i < MAX_ROOMS; i++) begin
         sum = sum + 5'(v[i]);
      end
      return sum;
   endfunction

endpackage

// File: rtl/room_light_ctrl_if.sv
// Sensor/override inputs and lamp/timer outputs of the lighting controller.
// master drives the sensors, slave is the controller side.
interface room_light_ctrl_if
   import room_light_pkg::*;
#(
   parameter int N_ROOMS = 8,
   parameter int CNT_W   = 4
);
   localparam int CW = cw(N_ROOMS);

   logic [N_ROOMS-1:0]       rooms;
   logic [N_ROOMS-1:0]       force_on;
   logic [CW-1:0]            count;
   logic [N_ROOMS*CNT_W-1:0] countdown;
   logic [N_ROOMS-1:0]       lightson;
   logic [N_ROOMS-1:0]       warn;

   modport master (
      output rooms, force_on,
      input  count, countdown, lightson, warn
   );

   modport slave (
      input  rooms, force_on,
      output count, countdown, lightson, warn
   );
endinterface

// File: rtl/room_light_chan.sv
// One room's hold-timer FSM (OFF / OCC / HOLD) with registered lamp enable.
// The pre-off warning flag is built only when ROOM_LIGHT_WARN_EN is defined.
module room_light_chan
   import room_light_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int HOLD_LOW = 10
`ifdef ROOM_LIGHT_WARN_EN
   ,
   parameter int WARN_LVL = 2
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             occupied_i,
   input  logic             force_i,
   input  logic             tick_i,
   input  logic [CNT_W-1:0] hold_i,
   output logic [CNT_W-1:0] countdown_o,
   output logic             light_o,
   output logic             warn_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: defaults first so every path assigns the next state; otherwise a latch is inferred.
      cnt_d   = cnt_q;
      state_d = state_q;
      if (occupied_i) begin
         cnt_d   = hold_i;
         state_d = OCC;
      end else if (force_i) begin
         cnt_d   = CNT_W'(HOLD_LOW);
         state_d = OCC;
      end else if (cnt_q != '0) begin
         state_d = HOLD;
         if (tick_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) state_d = OFF;
         end
      end else begin
         state_d = OFF;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         state_q <= OFF;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   // Every non-OFF state carries a non-zero timer, so the state doubles as the lamp register.
   assign countdown_o = cnt_q;
   assign light_o     = (state_q != OFF);

`ifdef ROOM_LIGHT_WARN_EN
   logic warn_q;

   always_ff @(posedge clk) begin
      if (rst) warn_q <= 1'b0;
      else     warn_q <= (state_d == HOLD) && (cnt_d != '0) && (int'(cnt_d) <= WARN_LVL);
   end

   assign warn_o = warn_q;
`else
   assign warn_o = 1'b0;
`endif

endmodule

// File: rtl/room_light_ctrl.sv
// N-room occupancy lighting controller: popcount, busy/quiet hold select, prescaler.
// Optional pre-off warning is enabled with ROOM_LIGHT_WARN_EN.
module room_light_ctrl
   import room_light_pkg::*;
#(
   parameter int N_ROOMS     = 8,
   parameter int CNT_W       = 4,
   parameter int HOLD_LOW    = 10,
   parameter int HOLD_HIGH   = 5,
   parameter int BUSY_THRESH = 6,
   parameter int TICK_DIV    = 1,
   parameter int WARN_LVL    = 2
) (
   input logic            clk,
   input logic            rst,
   room_light_ctrl_if.slave lc
);

   localparam int CW    = cw(N_ROOMS);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   if (N_ROOMS < 1 || N_ROOMS > MAX_ROOMS) begin : g_bad_rooms
      $fatal(1, "room_light_ctrl: N_ROOMS must be 1..16");
   end
   if (HOLD_LOW < 1 || HOLD_LOW > (2**CNT_W - 1)) begin : g_bad_low
      $fatal(1, "room_light_ctrl: HOLD_LOW out of range");
   end
   if (HOLD_HIGH < 1 || HOLD_HIGH > (2**CNT_W - 1)) begin : g_bad_high
      $fatal(1, "room_light_ctrl: HOLD_HIGH out of range");
   end
   if (TICK_DIV < 1) begin : g_bad_div
      $fatal(1, "room_light_ctrl: TICK_DIV must be at least 1");
   end
   if (WARN_LVL < 0) begin : g_bad_warn
      $fatal(1, "room_light_ctrl: WARN_LVL must not be negative");
   end

   logic [MAX_ROOMS-1:0] rooms_ext;
   logic [CW-1:0]        occ, count_q;
   logic                 busy, tick;
   logic [CNT_W-1:0]     hold;
   logic [PRE_W-1:0]     pre_q, pre_d;

   assign rooms_ext = MAX_ROOMS'(lc.rooms);
   assign occ       = CW'(popcount(rooms_ext));
   assign busy      = (int'(occ) >= BUSY_THRESH);
   assign hold      = busy ? CNT_W'(HOLD_HIGH) : CNT_W'(HOLD_LOW);

   // With TICK_DIV=1 the compare is against 0 and pre_q never leaves 0.
   assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
   assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         pre_q   <= '0;
      end else begin
         count_q <= occ;
         pre_q   <= pre_d;
      end
   end

   assign lc.count = count_q;

   for (genvar i = 0; i < N_ROOMS; i++) begin : g_chan
      room_light_chan #(
         .CNT_W    (CNT_W),
         .HOLD_LOW (HOLD_LOW)
`ifdef ROOM_LIGHT_WARN_EN
         ,
         .WARN_LVL (WARN_LVL)
`endif
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .occupied_i  (lc.rooms[i]),
         .force_i     (lc.force_on[i]),
         .tick_i      (tick),
         .hold_i      (hold),
         .countdown_o (lc.countdown[i*CNT_W +: CNT_W]),
         .light_o     (lc.lightson[i]),
         .warn_o      (lc.warn[i])
      );
   end

endmodule

// File: tb/tb_room_light_ctrl.sv
// Directed bench for room_light_ctrl: one TICK_DIV=1 instance and one TICK_DIV=3 instance.
// Warn expectations follow ROOM_LIGHT_WARN_EN.
module tb_room_light_ctrl;

`ifdef ROOM_LIGHT_WARN_EN
   localparam bit WARN_EN = 1'b1;
`else
   localparam bit WARN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   room_light_ctrl_if #(.N_ROOMS(8), .CNT_W(4)) lc1 ();
   room_light_ctrl_if #(.N_ROOMS(8), .CNT_W(4)) lc3 ();

   room_light_ctrl #(
      .N_ROOMS(8), .CNT_W(4), .HOLD_LOW(10), .HOLD_HIGH(5),
      .BUSY_THRESH(6), .TICK_DIV(1), .WARN_LVL(2)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .lc  (lc1)
   );

   room_light_ctrl #(
      .N_ROOMS(8), .CNT_W(4), .HOLD_LOW(10), .HOLD_HIGH(5),
      .BUSY_THRESH(6), .TICK_DIV(3), .WARN_LVL(2)
   ) u_dut3 (
      .clk (clk),
      .rst (rst),
      .lc  (lc3)
   );

   function automatic logic [3:0] cd1(input int i);
      return lc1.countdown[i*4 +: 4];
   endfunction

   function automatic logic [3:0] cd3(input int i);
      return lc3.countdown[i*4 +: 4];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      lc1.rooms    = '0;
      lc1.force_on = '0;
      lc3.rooms    = '0;
      lc3.force_on = '0;
      repeat (12) step();
      checks++;
      if (lc1.lightson !== 8'h00 || lc3.lightson !== 8'h00) begin
         errors++;
         $display("FAIL drain: lightson1=%h lightson3=%h, required 00", lc1.lightson, lc3.lightson);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      lc1.rooms    = 8'hFF;
      lc1.force_on = '0;
      lc3.rooms    = '0;
      lc3.force_on = '0;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (lc1.count !== 4'd0 || lc1.countdown !== 32'h0 || lc1.lightson !== 8'h00 ||
             lc1.warn !== 8'h00 || lc3.countdown !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: count=%0d countdown=%h lightson=%h warn=%h, required all 0",
                     lc1.count, lc1.countdown, lc1.lightson, lc1.warn);
         end
      end
      rst = 1'b0;
      step();
      checks++;
      if (lc1.count !== 4'd8 || lc1.countdown !== 32'h5555_5555 || lc1.lightson !== 8'hFF ||
          lc1.warn !== 8'h00) begin
         errors++;
         $display("FAIL reset_release: count=%0d countdown=%h lightson=%h warn=%h, required 8 55555555 ff 00",
                  lc1.count, lc1.countdown, lc1.lightson, lc1.warn);
      end
      drain();
   endtask

   task automatic test_quiet_hold();
      int on_cycles;
      logic exp_warn;
      lc1.rooms = 8'h01;
      step();
      on_cycles = lc1.lightson[0] ? 1 : 0;
      checks++;
      if (cd1(0) !== 4'd10 || lc1.count !== 4'd1 || lc1.warn[0] !== 1'b0) begin
         errors++;
         $display("FAIL quiet_load: countdown0=%0d count=%0d warn0=%b, required 10 1 0",
                  cd1(0), lc1.count, lc1.warn[0]);
      end
      lc1.rooms = 8'h00;
      for (int k = 9; k >= 0; k--) begin
         step();
         exp_warn = WARN_EN && (k == 2 || k == 1);
         if (lc1.lightson[0]) on_cycles++;
         checks++;
         if (cd1(0) !== 4'(k) || lc1.lightson[0] !== (k != 0) || lc1.warn[0] !== exp_warn) begin
            errors++;
            $display("FAIL quiet_decay: countdown0=%0d lightson0=%b warn0=%b, required %0d %b %b",
                     cd1(0), lc1.lightson[0], lc1.warn[0], k, (k != 0), exp_warn);
         end
      end
      checks++;
      if (on_cycles !== 10) begin
         errors++;
         $display("FAIL quiet_on_time: lamp on %0d cycles, required 10", on_cycles);
      end
      drain();
   endtask

   task automatic test_busy_switch();
      // Five rooms is one below the threshold: still the quiet reload.
      lc1.rooms = 8'h1F;
      step();
      checks++;
      if (lc1.count !== 4'd5 || cd1(0) !== 4'd10 || cd1(4) !== 4'd10) begin
         errors++;
         $display("FAIL busy_below_thresh: count=%0d countdown0=%0d countdown4=%0d, required 5 10 10",
                  lc1.count, cd1(0), cd1(4));
      end
      lc1.rooms = 8'h3F;
      step();
      checks++;
      if (lc1.count !== 4'd6 || lc1.countdown !== 32'h0055_5555) begin
         errors++;
         $display("FAIL busy_at_thresh: count=%0d countdown=%h, required 6 00555555",
                  lc1.count, lc1.countdown);
      end
      lc1.rooms = 8'h01;
      step();
      checks++;
      if (lc1.count !== 4'd1 || lc1.countdown !== 32'h0044_444A) begin
         errors++;
         $display("FAIL busy_to_quiet: count=%0d countdown=%h, required 1 0044444a",
                  lc1.count, lc1.countdown);
      end
      drain();
   endtask

   task automatic test_prescaler();
      int  on_cycles, since, decs;
      bit  done;
      logic [3:0] prev, v;
      lc3.rooms = 8'h02;
      step();
      checks++;
      if (cd3(1) !== 4'd10 || lc3.lightson[1] !== 1'b1) begin
         errors++;
         $display("FAIL presc_load: countdown1=%0d lightson1=%b, required 10 1", cd3(1), lc3.lightson[1]);
      end
      lc3.rooms = 8'h00;
      on_cycles = 1;
      since     = 0;
      decs      = 0;
      done      = 1'b0;
      prev      = cd3(1);
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         v = cd3(1);
         since++;
         if (v != prev) begin
            checks++;
            if (v !== prev - 4'd1 || (decs == 0 && since > 3) || (decs != 0 && since != 3)) begin
               errors++;
               $display("FAIL presc_step: countdown1=%0d after %0d cycles, required %0d after 3 cycles",
                        v, since, prev - 4'd1);
            end
            decs++;
            since = 0;
            prev  = v;
         end
         if (lc3.lightson[1]) on_cycles++;
         else                 done = 1'b1;
      end
      checks++;
      if (!done || on_cycles < 28 || on_cycles > 30) begin
         errors++;
         $display("FAIL presc_off_time: lamp on %0d cycles (off seen=%b), required 28..30", on_cycles, done);
      end
      drain();
   endtask

   task automatic test_force_on();
      logic exp_warn;
      lc1.force_on = 8'h80;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (lc1.count !== 4'd0 || cd1(7) !== 4'd10 || lc1.lightson[7] !== 1'b1 || lc1.warn[7] !== 1'b0) begin
            errors++;
            $display("FAIL force_hold: count=%0d countdown7=%0d lightson7=%b warn7=%b, required 0 10 1 0",
                     lc1.count, cd1(7), lc1.lightson[7], lc1.warn[7]);
         end
      end
      lc1.force_on = 8'h00;
      for (int k = 9; k >= 0; k--) begin
         step();
         exp_warn = WARN_EN && (k == 2 || k == 1);
         checks++;
         if (cd1(7) !== 4'(k) || lc1.lightson[7] !== (k != 0) || lc1.warn[7] !== exp_warn) begin
            errors++;
            $display("FAIL force_release: countdown7=%0d lightson7=%b warn7=%b, required %0d %b %b",
                     cd1(7), lc1.lightson[7], lc1.warn[7], k, (k != 0), exp_warn);
         end
      end
      drain();
   endtask

   task automatic test_mid_hold_reset();
      lc1.rooms = 8'h01;
      step();
      lc1.rooms = 8'h00;
      repeat (6) step();
      checks++;
      if (cd1(0) !== 4'd4) begin
         errors++;
         $display("FAIL mid_reset_pre: countdown0=%0d, required 4", cd1(0));
      end
      rst = 1'b1;
      step();
      checks++;
      if (lc1.countdown !== 32'h0 || lc1.lightson !== 8'h00 || lc1.warn !== 8'h00 || lc1.count !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset_clear: countdown=%h lightson=%h warn=%h count=%0d, required all 0",
                  lc1.countdown, lc1.lightson, lc1.warn, lc1.count);
      end
      rst = 1'b0;
      step();
      checks++;
      if (lc1.countdown !== 32'h0 || lc1.lightson !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_after: countdown=%h lightson=%h, required 0 00", lc1.countdown, lc1.lightson);
      end
   endtask

   task automatic test_reoccupy();
      int drops;
      drops     = 0;
      lc1.rooms = 8'h04;
      step();
      lc1.rooms = 8'h00;
      for (int c = 0; c < 9; c++) begin
         step();
         if (!lc1.lightson[2]) drops++;
      end
      checks++;
      if (cd1(2) !== 4'd1) begin
         errors++;
         $display("FAIL reocc_pre: countdown2=%0d, required 1", cd1(2));
      end
      lc1.rooms = 8'h04;
      step();
      if (!lc1.lightson[2]) drops++;
      checks++;
      if (cd1(2) !== 4'd10 || drops !== 0) begin
         errors++;
         $display("FAIL reocc_reload: countdown2=%0d lamp drops=%0d, required 10 0", cd1(2), drops);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_quiet_hold();
      test_busy_switch();
      test_prescaler();
      test_force_on();
      test_mid_hold_reset();
      test_reoccupy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
